// File: rtl/prng_seq_div_if.sv
// prng_seq_div_if: operand and result handshake bundle for the restoring divider
interface prng_seq_div_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, out_valid, out_ready, div_zero, overflow;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor, quotient, remainder;
  modport master (output in_valid, dividend, divisor, out_ready,
                  input in_ready, out_valid, quotient, remainder, div_zero, overflow);
  modport slave (input in_valid, dividend, divisor, out_ready,
                 output in_ready, out_valid, quotient, remainder, div_zero, overflow);
endinterface

// File: rtl/prng_seq_div.sv
// prng_seq_div: iterative radix-2 restoring divider, 2W-bit dividend by W-bit divisor
module prng_seq_div #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  prng_seq_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH:0] shifted;
  logic [WIDTH-1:0] r, r_nx, q, q_nx, d, quo, rem;
  logic [CW-1:0] cnt;
  logic dz, ov, zero, big, ge, last, accept;
  assign zero = bus.divisor == '0;
  assign big = bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor;
  assign accept = state == IDLE && bus.in_valid;
  assign last = cnt == CW'(WIDTH - 1);
  // partial remainder stays below d, so only the shifted value needs the extra bit
  assign shifted = {r, q[WIDTH-1]};
  assign ge = shifted >= {1'b0, d};
  assign r_nx = ge ? WIDTH'(shifted - {1'b0, d}) : shifted[WIDTH-1:0];
  assign q_nx = {q[WIDTH-2:0], ge};
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.quotient = quo;
  assign bus.remainder = rem;
  assign bus.div_zero = dz;
  assign bus.overflow = ov;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.in_valid) state_nx = (zero || big) ? DONE : BUSY;
      BUSY: if (last) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dz <= 1'b0;
      ov <= 1'b0;
    end else if (accept) begin
      r <= bus.dividend[2*WIDTH-1:WIDTH];
      q <= bus.dividend[WIDTH-1:0];
      d <= bus.divisor;
      cnt <= '0;
      if (zero || big) begin
        quo <= '1;
        rem <= zero ? bus.dividend[WIDTH-1:0] : '0;
        dz <= zero;
        ov <= !zero;
      end
    end else if (state == BUSY) begin
      r <= r_nx;
      q <= q_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        quo <= q_nx;
        rem <= r_nx;
        dz <= 1'b0;
        ov <= 1'b0;
      end
    end
endmodule

// File: tb/tb_prng_seq_div.sv
// tb_prng_seq_div: table vectors, random a*b+c sweep and reset corner cases
module tb_prng_seq_div;
  typedef struct {
    logic [63:0] dvd;
    logic [31:0] dvs, q, r;
    logic dz, ov;
    int hold;
    bit inject;
  } vec_t;
  typedef struct {
    logic [31:0] q, r;
    logic dz, ov;
    int lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  vec_t tbl[11];
  prng_seq_div_if #(.WIDTH(32)) bus();
  prng_seq_div #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic do_op(input vec_t v);
    exp_t e;
    int lat;
    bit busy_bad;
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.dividend = v.dvd;
    bus.divisor = v.dvs;
    sb.push_back('{v.q, v.r, v.dz, v.ov, (v.dz || v.ov) ? 0 : 32});
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dividend = {$urandom, $urandom};
    bus.divisor = $urandom;
    lat = 0;
    busy_bad = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) busy_bad = 1'b1;
      bus.in_valid = v.inject && lat == 5;
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    e = sb.pop_front();
    check("out_valid", 64'(bus.out_valid), 64'd1);
    check("latency", 64'(lat), 64'(e.lat));
    check("in_ready_busy", 64'(busy_bad), 64'd0);
    check("quotient", 64'(bus.quotient), 64'(e.q));
    check("remainder", 64'(bus.remainder), 64'(e.r));
    check("div_zero", 64'(bus.div_zero), 64'(e.dz));
    check("overflow", 64'(bus.overflow), 64'(e.ov));
    check("in_ready_done", 64'(bus.in_ready), 64'd0);
    if (v.hold > 0) begin
      repeat (v.hold) @(negedge clk);
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("hold_result", {bus.quotient, bus.remainder}, {e.q, e.r});
      check("hold_flags", 64'({bus.div_zero, bus.overflow}), 64'({e.dz, e.ov}));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("released_valid", 64'(bus.out_valid), 64'd0);
    check("released_in_ready", 64'(bus.in_ready), 64'd1);
    if (v.inject) begin
      @(negedge clk);
      check("no_ghost_result", 64'(bus.out_valid), 64'd0);
    end
  endtask
  initial begin
    vec_t v;
    logic [31:0] a, b, c;
    tbl[0] = '{64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 0, 1'b0};
    tbl[1] = '{64'hFFFFFFFE00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 5, 1'b0};
    tbl[2] = '{64'h0000000500000009, 32'd0, 32'hFFFFFFFF, 32'd9, 1'b1, 1'b0, 0, 1'b0};
    tbl[3] = '{64'h0000000800000000, 32'd8, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 5, 1'b0};
    tbl[4] = '{64'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b0};
    tbl[5] = '{64'h00000006FFFFFFFF, 32'd7, 32'hFFFFFFFF, 32'd6, 1'b0, 1'b0, 0, 1'b0};
    tbl[6] = '{64'h0000000012345678, 32'd1, 32'h12345678, 32'd0, 1'b0, 1'b0, 0, 1'b0};
    tbl[7] = '{64'h0000000700000000, 32'd7, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 0, 1'b0};
    tbl[8] = '{64'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 0, 1'b0};
    tbl[9] = '{64'h00000000FFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 0, 1'b0};
    tbl[10] = '{64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 5, 1'b1};
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", {bus.quotient, bus.remainder}, 64'd0);
    check("rst_flags", 64'({bus.div_zero, bus.overflow}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 11; i++) do_op(tbl[i]);
    bus.in_valid = 1'b1;
    bus.dividend = 64'd200;
    bus.divisor = 32'd9;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_result", {bus.quotient, bus.remainder}, 64'd0);
    check("midrst_flags", 64'({bus.div_zero, bus.overflow}), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(tbl[0]);
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      if (b == 0) b = 32'd1;
      c = $urandom_range(b - 1, 0);
      v = '{64'(a) * 64'(b) + 64'(c), b, a, c, 1'b0, 1'b0, 0, 1'b0};
      do_op(v);
    end
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
